// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command processor.
// Holds opcode constants, the command FSM state type, status-byte bit positions
// and a saturating increment helper for the 4-bit error counter.
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_LED_ON  = 8'h01;
  localparam logic [7:0] OP_LED_OFF = 8'h02;
  localparam logic [7:0] OP_TOGGLE  = 8'h03;
  localparam logic [7:0] OP_SET_PWM = 8'h10;
  localparam logic [7:0] OP_STATUS  = 8'h20;
  localparam logic [7:0] OP_ECHO    = 8'h21;
  localparam logic [7:0] OP_CLR_ERR = 8'h30;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_WAIT_ARG
  } state_e;

  // Status byte layout: {led_on, err, fifo_full, fifo_empty, err_cnt[3:0]}
  localparam int unsigned STAT_LED_ON  = 7;
  localparam int unsigned STAT_ERR     = 6;
  localparam int unsigned STAT_FULL    = 5;
  localparam int unsigned STAT_EMPTY   = 4;
  localparam int unsigned STAT_CNT_MSB = 3;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/spi_cmd_ctrl_byte_fifo.sv
// byte_fifo: small 8-bit FIFO used for the reply path.
// Ports: clk, rst_n (async active-low), push/push_data, pop,
//        head (entry at the read pointer, 0x00 when empty), full, empty.
// A pop while empty is ignored; a push while full lands only if a pop
// takes effect in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_eff, pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_eff) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_eff) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_eff, pop_eff})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: decodes command bytes from spi_slave, drives a PWM-gated LED
// and queues reply bytes for spi_slave to shift out.
// Ports: ext_clk, rst_n (async active-low), recv_data/recv_ready (incoming byte),
//        send_ready (reply byte captured), send_data (reply FIFO head),
//        led (PWM-gated drive), err (sticky error flag).
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ARG_TIMEOUT = 4096
) (
  input  logic       ext_clk,
  input  logic       rst_n,
  input  logic [7:0] recv_data,
  input  logic       recv_ready,
  input  logic       send_ready,
  output logic [7:0] send_data,
  output logic       led,
  output logic       err
);

  localparam int unsigned TMO_W = $clog2(ARG_TIMEOUT);

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             led_on_q, led_on_d;
  logic [7:0]       duty_q, duty_d;
  logic [7:0]       pwm_cnt_q;
  logic             err_q;
  logic [3:0]       err_cnt_q;

  logic       push;
  logic [7:0] push_data;
  logic       fifo_full, fifo_empty;
  logic       err_set, err_clr, overflow;
  logic [7:0] status;

  always_comb begin
    status                          = 8'h00;
    status[STAT_LED_ON]             = led_on_q;
    status[STAT_ERR]                = err_q;
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_CNT_MSB:0]          = err_cnt_q;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    tmo_d     = tmo_q;
    led_on_d  = led_on_q;
    duty_d    = duty_q;
    push      = 1'b0;
    push_data = 8'h00;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (recv_ready) begin
          case (recv_data)
            OP_NOP:     ;
            OP_LED_ON:  led_on_d = 1'b1;
            OP_LED_OFF: led_on_d = 1'b0;
            OP_TOGGLE:  led_on_d = ~led_on_q;
            OP_SET_PWM, OP_ECHO: begin
              state_d = ST_WAIT_ARG;
              op_d    = recv_data;
              tmo_d   = '0;
            end
            OP_STATUS: begin
              push      = 1'b1;
              push_data = status;
            end
            OP_CLR_ERR: err_clr = 1'b1;
            default:    err_set = 1'b1;
          endcase
        end
      end
      ST_WAIT_ARG: begin
        if (recv_ready) begin
          state_d = ST_IDLE;
          if (op_q == OP_SET_PWM) begin
            duty_d = recv_data;
          end else begin
            push      = 1'b1;
            push_data = recv_data;
          end
        end else if (tmo_q == TMO_W'(ARG_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Full FIFO implies non-empty, so a concurrent send_ready always frees a slot.
  assign overflow = push & fifo_full & ~send_ready;

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      tmo_q     <= '0;
      led_on_q  <= 1'b1;
      duty_q    <= 8'hFF;
      pwm_cnt_q <= 8'h00;
      err_q     <= 1'b0;
      err_cnt_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      led_on_q  <= led_on_d;
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + 8'd1;
      if (err_clr) begin
        err_q     <= 1'b0;
        err_cnt_q <= 4'h0;
      end else if (err_set | overflow) begin
        err_q     <= 1'b1;
        err_cnt_q <= sat_inc4(err_cnt_q);
      end
    end
  end

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_reply_fifo (
    .clk       (ext_clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (send_ready),
    .head      (send_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign led = led_on_q & ((duty_q == 8'hFF) | (pwm_cnt_q < duty_q));
  assign err = err_q;

endmodule
